// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    mem_size_t       size;
    logic            is_unsigned;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // The reserved size encoding behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] low);
    case (size)
      SZ_HALF: return low[0];
      SZ_WORD: return low != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_size_t       size,
  input  logic [1:0]      lane,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merge_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_sign;
  logic        half_sign;

  assign byte_sel  = rdata[{lane, 3'b000} +: 8];
  assign half_sel  = rdata[{lane[1], 4'b0000} +: 16];
  assign byte_sign = ~is_unsigned & byte_sel[7];
  assign half_sign = ~is_unsigned & half_sel[15];

  // Little-endian: lane 0 is the least significant byte of the word.
  always_comb begin
    load_data_c  = rdata;
    merge_data_c = wdata;
    case (size)
      SZ_BYTE: begin
        load_data_c  = {{24{byte_sign}}, byte_sel};
        merge_data_c = rdata;
        merge_data_c[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data_c  = {{16{half_sign}}, half_sel};
        merge_data_c = rdata;
        merge_data_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data_c  = rdata;
        merge_data_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Optional LSU_CHECK_EN adds misalignment and range fault detection.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state;
  lsu_req_t        req_q;
  mem_size_t       in_size_c;
  logic            in_fault_c;
  logic            cur_fault_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] merge_data_c;

  assign in_size_c = decode_size(req_size);

`ifdef LSU_CHECK_EN
  function automatic logic fault_of(input mem_size_t size, input logic [XLEN-1:0] addr);
    return misaligned(size, addr[1:0]) || (32'(addr[XLEN-1:2]) >= 32'(MEM_WORDS));
  endfunction

  // The incoming check lets a faulting word store suppress mem_we from the first cycle.
  assign in_fault_c  = fault_of(in_size_c, req_addr);
  assign cur_fault_c = fault_of(req_q.size, req_q.addr);
`else
  assign in_fault_c  = 1'b0;
  assign cur_fault_c = 1'b0;
`endif

  lsu_align u_align (
    .size         (req_q.size),
    .lane         (req_q.addr[1:0]),
    .is_unsigned  (req_q.is_unsigned),
    .rdata        (mem_rdata),
    .wdata        (req_q.wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Request sequencing; mem_addr is set at transfer so mem_rdata is valid in ACCESS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q.we          <= req_we;
            req_q.size        <= in_size_c;
            req_q.is_unsigned <= req_unsigned;
            req_q.addr        <= req_addr;
            req_q.wdata       <= req_wdata;
            req_ready         <= 1'b0;
            mem_addr          <= {req_addr[XLEN-1:2], 2'b00};
            mem_wdata         <= req_wdata;
            mem_we            <= req_we && (in_size_c == SZ_WORD) && !in_fault_c;
            state             <= ACCESS;
          end
        end
        ACCESS: begin
          mem_addr <= {req_q.addr[XLEN-1:2], 2'b00};
          if (!req_q.we) begin
            resp_rdata <= cur_fault_c ? '0 : load_data_c;
            resp_error <= cur_fault_c;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if ((req_q.size == SZ_WORD) || cur_fault_c) begin
            resp_rdata <= '0;
            resp_error <= cur_fault_c;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_wdata <= merge_data_c;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          resp_rdata <= '0;
          resp_error <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-level reference model, directed spec cases, random traffic.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  // Data memory seen by the DUT, and the model's view of what it must contain.
  logic [31:0] dmem [64];
  logic [31:0] model_mem [64];
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clock) if (mem_we) dmem[mem_addr[7:2]] = mem_wdata;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Outstanding-request expectations shared with the monitor.
  bit          pending = 1'b0;
  bit          manual = 1'b0;
  int          xfer_cyc;
  int          exp_lat;
  int          exp_we;
  int          we_cnt;
  int          idx;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] exp_mem_addr;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  int          last_we;

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (!reset && !manual) begin
      if (mem_we) begin
        if (pending) begin
          we_cnt++;
          check32("mem_addr", mem_addr, exp_mem_addr);
        end else begin
          check32("stray_mem_we", 32'(mem_we), 32'd0);
        end
      end
      if (pending) begin
        check32("ready_busy", 32'(req_ready), 32'd0);
        if (resp_valid) begin
          last_lat   = cyc - xfer_cyc + 1;
          last_rdata = resp_rdata;
          last_err   = resp_error;
          last_we    = we_cnt;
          check32("latency", 32'(last_lat), 32'(exp_lat));
          check32("resp_rdata", resp_rdata, exp_rdata);
          check32("resp_error", 32'(resp_error), 32'(exp_err));
          check32("mem_we_cycles", 32'(we_cnt), 32'(exp_we));
          check32("mem_word", dmem[idx], model_mem[idx]);
          pending = 1'b0;
        end else if (cyc - xfer_cyc > 6) begin
          check32("resp_timeout", 32'(resp_valid), 32'd1);
          pending = 1'b0;
        end
      end else begin
        check32("spurious_resp", 32'(resp_valid), 32'd0);
        check32("ready_idle", 32'(req_ready), 32'd1);
      end
    end else if (manual) begin
      check32("abort_resp", 32'(resp_valid), 32'd0);
    end
  end

  // Model: compute response and memory effect from byte lanes.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int n, off;
    logic [7:0] b [4];
    logic [31:0] w, v;
    bit f;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = (size == 2'd0) ? int'(addr[1:0]) : (size == 2'd1) ? (addr[1] ? 2 : 0) : 0;
    f   = 1'b0;
`ifdef LSU_CHECK_EN
    f = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
`endif
    idx = int'(addr[7:2]);
    w = model_mem[idx];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(b[off+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    if (we && !f) begin
      for (int i = 0; i < n; i++) b[off+i] = wdata[8*i +: 8];
      model_mem[idx] = {b[3], b[2], b[1], b[0]};
    end
    exp_rdata    = (we || f) ? 32'd0 : v;
    exp_err      = f;
    exp_lat      = (we && n < 4 && !f) ? 3 : 2;
    exp_we       = (we && !f) ? 1 : 0;
    exp_mem_addr = {addr[31:2], 2'b00};
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    we_cnt = 0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    xfer_cyc = cyc;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    drive(we, size, uns, addr, wdata);
    model_req(we, size, uns, addr, wdata);
    pending = 1'b1;
    for (int k = 0; k < 12 && pending; k++) @(posedge clock);
    if (pending) begin
      check32("req_wait", 32'(pending), 32'd0);
      pending = 1'b0;
    end
  endtask

  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    dmem[0] = 32'h64;  model_mem[0] = 32'h64;
    dmem[1] = 32'hC8;  model_mem[1] = 32'hC8;
    dmem[2] = 32'h12C; model_mem[2] = 32'h12C;

    #1 reset = 1'b1;
    #11;
    check32("rst_ready", 32'(req_ready), 32'd1);
    check32("rst_resp_valid", 32'(resp_valid), 32'd0);
    check32("rst_rdata", resp_rdata, 32'd0);
    check32("rst_error", 32'(resp_error), 32'd0);
    check32("rst_mem_we", 32'(mem_we), 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases with hand-computed results.
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    check32("t1_rdata", last_rdata, 32'h0000012C);
    check32("t1_lat", 32'(last_lat), 32'd2);
    check32("t1_we", 32'(last_we), 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
`ifdef LSU_CHECK_EN
    check32("t5_err", 32'(last_err), 32'd1);
    check32("t5_rdata", last_rdata, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    check32("t5_st_err", 32'(last_err), 32'd1);
    check32("t5_st_we", 32'(last_we), 32'd0);
`else
    check32("t5_rdata", last_rdata, 32'h000000C8);
`endif

    do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h80FF7F01);
    check32("t2_word3", dmem[3], 32'h80FF7F01);
    do_req(1'b0, 2'b00, 1'b0, 32'hD, 32'h0);
    check32("t2_sb_d", last_rdata, 32'h0000007F);
    do_req(1'b0, 2'b00, 1'b0, 32'hE, 32'h0);
    check32("t2_sb_e", last_rdata, 32'hFFFFFFFF);
    do_req(1'b0, 2'b00, 1'b1, 32'hE, 32'h0);
    check32("t2_ub_e", last_rdata, 32'h000000FF);
    do_req(1'b0, 2'b01, 1'b0, 32'hE, 32'h0);
    check32("t2_sh_e", last_rdata, 32'hFFFF80FF);

    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AB);
    check32("t3_word1", dmem[1], 32'h0000ABC8);
    check32("t3_we", 32'(last_we), 32'd1);
    check32("t3_lat", 32'(last_lat), 32'd3);

    do_req(1'b1, 2'b01, 1'b0, 32'h2, 32'h00001234);
    check32("t4_word0", dmem[0], 32'h12340064);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check32("t4_load", last_rdata, 32'h12340064);

    // Random traffic; addresses past the memory exercise wrap or range faults.
    for (int r = 0; r < 120; r++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 511)), $urandom);
    end

    // Reset during the write cycle of a byte store.
    saved = dmem[4];
    manual = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A);
    @(posedge clock);
    #1;
    check32("abort_we_before", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    check32("abort_we_async", 32'(mem_we), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check32("abort_ready", 32'(req_ready), 32'd1);
    check32("abort_mem", dmem[4], saved);
    repeat (4) @(negedge clock);
    manual = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check32("abort_reload", last_rdata, saved);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
